perf_counter_dump: RTL

PERF_COUNTER_DUMP -- requirements
Module: perf_counter_dump

---
 rtl/perf_counter_dump.sv | 67 ++++++
 1 files changed

// File: rtl/perf_counter_dump.sv
// perf_counter_dump: sweeps a counter bank and streams each value, optionally clearing it after reading
module perf_counter_dump #(
  parameter int XLEN = 64,
  parameter int NUM_CNT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            clear_on_read_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [4:0]      addr_o,
  output logic            we_o,
  output logic [XLEN-1:0] wdata_o,
  input  logic [XLEN-1:0] rdata_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_data_o,
  output logic [4:0]      out_idx_o,
  output logic            out_last_o
);
  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, DONE} state_t;
  localparam logic [4:0] LAST = 5'(NUM_CNT - 1);
  state_t state, state_nxt;
  logic [4:0] idx;
  logic clr;
  logic hs;
  assign hs = state == SEND && out_ready_i;
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE    ? (start_i ? CAPTURE : IDLE) :
                abort_i          ? IDLE :
                state == CAPTURE ? SEND :
                state == SEND    ? (out_ready_i ? (idx == LAST ? DONE : CAPTURE) : SEND) :
                                   IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx        <= '0;
      clr        <= 1'b0;
      out_data_o <= '0;
      out_idx_o  <= '0;
      out_last_o <= 1'b0;
    end else begin
      if (state == IDLE && start_i) begin
        idx <= '0;
        clr <= clear_on_read_i;
      end
      if (state == CAPTURE) begin
        out_data_o <= rdata_i;
        out_idx_o  <= idx;
        out_last_o <= idx == LAST;
      end
      if (hs && idx != LAST) idx <= idx + 5'd1;
    end
  end
  // the bank sees the read and the clear write in the same cycle, so the captured value is pre-clear
  always_comb begin
    busy_o      = state != IDLE;
    done_o      = state == DONE && !abort_i;
    out_valid_o = state == SEND;
    we_o        = state == CAPTURE && clr;
    addr_o      = state == CAPTURE ? idx : 5'd0;
    wdata_o     = '0;
  end
endmodule
